// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration count.
package muldiv_unit_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final state.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         stall,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [2*N-1:0]     acc_q;
    logic [N-1:0]       opnd_q;
    logic               is_div_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               done_q;
    logic [N-1:0]       hi_q, lo_q;

    op_e                op_in;
    logic               in_div, in_signed, in_neg, in_rem_neg;
    logic [N-1:0]       a_mag, b_mag;

    logic [N:0]         mul_sum;
    logic [2*N-1:0]     mul_step;
    logic [N:0]         rem_sh;
    logic               rem_ge;
    logic [N-1:0]       rem_sub;
    logic [2*N-1:0]     div_step;
    logic [2*N-1:0]     prod_fix;
    logic [N-1:0]       fix_hi, fix_lo;

    // Operand preparation for the IDLE latch.
    always_comb begin
        op_in      = op_e'(op);
        in_div     = (op_in == OP_DIVU) || (op_in == OP_DIV);
        in_signed  = (op_in == OP_MULT) || (op_in == OP_DIV);
        a_mag      = (in_signed && a[N-1]) ? (~a + 1'b1) : a;
        b_mag      = (in_signed && b[N-1]) ? (~b + 1'b1) : b;
        // A zero divisor must leave the all-ones quotient un-negated.
        in_neg     = in_signed && (a[N-1] ^ b[N-1]) && !(in_div && (b == '0));
        in_rem_neg = in_signed && in_div && a[N-1];
    end

    // One iteration step for each operation, plus the final sign correction.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {mul_sum, acc_q[N-1:1]};

        rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
        rem_ge   = rem_sh >= {1'b0, opnd_q};
        rem_sub  = rem_sh[N-1:0] - opnd_q;
        div_step = rem_ge ? {rem_sub,       acc_q[N-2:0], 1'b1}
                          : {rem_sh[N-1:0], acc_q[N-2:0], 1'b0};

        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        if (is_div_q) begin
            fix_lo = neg_q     ? (~acc_q[N-1:0]   + 1'b1) : acc_q[N-1:0];
            fix_hi = rem_neg_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
        end else begin
            fix_lo = prod_fix[N-1:0];
            fix_hi = prod_fix[2*N-1:N];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: if (count_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_FIX);
        end
    end

    // NOTE: datapath registers are reset too, so an abandoned operation leaves hi/lo at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_q   <= '0;
                        acc_q     <= {{N{1'b0}}, (in_div ? a_mag : b_mag)};
                        opnd_q    <= in_div ? b_mag : a_mag;
                        is_div_q  <= in_div;
                        neg_q     <= in_neg;
                        rem_neg_q <= in_rem_neg;
                    end
                end
                ST_CALC: begin
                    acc_q   <= is_div_q ? div_step : mul_step;
                    count_q <= count_q + 1'b1;
                end
                ST_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign stall = busy | (start & busy);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
